// File: rtl/icache_fill_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// icache_fill_ctrl_pkg
// Shared definitions for the instruction-cache fill controller:
//   - cache geometry widths (128 lines x 8 bytes, 22-bit tag)
//   - memory-bus command encodings
//   - fill FSM state enum
//   - helper that splits a line address into cache index and tag
// -----------------------------------------------------------------------------
package icache_fill_ctrl_pkg;

   localparam int IDX_W  = 7;   // 128 cache lines
   localparam int TAG_W  = 22;  // address bits [31:10]
   localparam int OFF_W  = 3;   // 8-byte line
   localparam int MTAG_W = 4;   // memory transaction tag, 0 = no transaction

   localparam logic [1:0] BUS_NONE = 2'd0;
   localparam logic [1:0] BUS_LOAD = 2'd1;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } fill_state_e;

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [IDX_W-1:0] idx;
   } line_addr_t;

   // Line address is the fetch address with the byte offset dropped
   // (bits [31:3]); low bits are the index, high bits the tag.
   function automatic line_addr_t split_line(input logic [IDX_W+TAG_W-1:0] line);
      line_addr_t la;
      la.idx = line[IDX_W-1:0];
      la.tag = line[IDX_W+TAG_W-1:IDX_W];
      return la;
   endfunction

endpackage

// File: rtl/icache_fill_ctrl.sv
// -----------------------------------------------------------------------------
// icache_fill_ctrl
// Write-side controller for the 128x64 direct-mapped instruction cache.
// Splits the fetch address into index/tag for the cache read port, detects
// misses, issues one tagged load to instruction memory and installs the
// returning line through the cache write port.
//
// Optional feature (macro ICACHE_FILL_BYPASS_EN): in the fill cycle, if the
// current fetch address matches the line being filled, the memory data is
// forwarded straight to Icache_data_out / Icache_valid_out.
//
// Ports:
//   clock, reset            clock, asynchronous active-high reset
//   proc2Icache_addr        fetch address (bits [31:3] used)
//   cachemem_data/valid     cache read data / hit
//   Imem2proc_response      nonzero: load accepted with this tag
//   Imem2proc_data/tag      returning data and its tag (tag 0 = none)
//   rd_idx, rd_tag          cache read port (combinational from address)
//   wr_en/idx/tag/data      cache write port (fill)
//   proc2Imem_command/addr  memory request
//   Icache_data_out/valid   instruction to the fetch stage
//   dbg_state               current fill FSM state
//
// Bus handshake: a BUS_LOAD is taken only in the cycle Imem2proc_response is
// nonzero; that value tags the transaction. Data returns in a later cycle in
// which Imem2proc_tag equals that tag. Other tags belong to other clients and
// are ignored. A refused request (response 0) leaves no state behind.
// -----------------------------------------------------------------------------
module icache_fill_ctrl
   import icache_fill_ctrl_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic [63:0]       proc2Icache_addr,
   input  logic [63:0]       cachemem_data,
   input  logic              cachemem_valid,
   input  logic [MTAG_W-1:0] Imem2proc_response,
   input  logic [63:0]       Imem2proc_data,
   input  logic [MTAG_W-1:0] Imem2proc_tag,
   output logic [IDX_W-1:0]  rd_idx,
   output logic [TAG_W-1:0]  rd_tag,
   output logic              wr_en,
   output logic [IDX_W-1:0]  wr_idx,
   output logic [TAG_W-1:0]  wr_tag,
   output logic [63:0]       wr_data,
   output logic [1:0]        proc2Imem_command,
   output logic [63:0]       proc2Imem_addr,
   output logic [63:0]       Icache_data_out,
   output logic              Icache_valid_out,
   output fill_state_e       dbg_state
);

   fill_state_e       state;
   logic [IDX_W-1:0]  miss_idx;
   logic [TAG_W-1:0]  miss_tag;
   logic [MTAG_W-1:0] pend_mtag;

   line_addr_t        cur_line;
   logic              issue_load;
   logic              fill;
   logic              unused_addr_bits;

   assign unused_addr_bits = ^{proc2Icache_addr[63:32], proc2Icache_addr[OFF_W-1:0]};

   assign cur_line = split_line(proc2Icache_addr[31:OFF_W]);
   assign rd_idx   = cur_line.idx;
   assign rd_tag   = cur_line.tag;

   // Request only from IDLE on a miss; WAIT keeps a single load outstanding.
   assign issue_load = !reset && (state == IDLE) && !cachemem_valid;
   // pend_mtag is nonzero in WAIT; the extra test keeps tag 0 ("no data")
   // from ever looking like a match.
   assign fill       = (state == WAIT) && (pend_mtag != '0) && (Imem2proc_tag == pend_mtag);

   assign proc2Imem_command = issue_load ? BUS_LOAD : BUS_NONE;
   assign proc2Imem_addr    = {32'b0, proc2Icache_addr[31:OFF_W], {OFF_W{1'b0}}};

   assign wr_en   = fill;
   assign wr_idx  = miss_idx;
   assign wr_tag  = miss_tag;
   assign wr_data = Imem2proc_data;

`ifdef ICACHE_FILL_BYPASS_EN
   logic bypass_hit;
   assign bypass_hit       = fill && (rd_idx == miss_idx) && (rd_tag == miss_tag);
   assign Icache_valid_out = !reset && (cachemem_valid || bypass_hit);
   assign Icache_data_out  = bypass_hit ? Imem2proc_data : cachemem_data;
`else
   assign Icache_valid_out = !reset && cachemem_valid;
   assign Icache_data_out  = cachemem_data;
`endif

   assign dbg_state = state;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         miss_idx  <= '0;
         miss_tag  <= '0;
         pend_mtag <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (issue_load && (Imem2proc_response != '0)) begin
                  pend_mtag <= Imem2proc_response;
                  miss_idx  <= rd_idx;
                  miss_tag  <= rd_tag;
                  state     <= WAIT;
               end
            end
            WAIT: begin
               // Address changes here are ignored: the old line still fills.
               if (fill) begin
                  pend_mtag <= '0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// -----------------------------------------------------------------------------
// tb_icache_fill_ctrl
// Directed bench for icache_fill_ctrl. Inputs change #1 after the rising edge;
// outputs are checked mid-cycle. Accepted misses push their expected
// {tag, idx} into exp_q; each fill pops and compares the write port.
// -----------------------------------------------------------------------------
module tb_icache_fill_ctrl;
   import icache_fill_ctrl_pkg::*;

   logic              clock;
   logic              reset;
   logic [63:0]       proc2Icache_addr;
   logic [63:0]       cachemem_data;
   logic              cachemem_valid;
   logic [MTAG_W-1:0] Imem2proc_response;
   logic [63:0]       Imem2proc_data;
   logic [MTAG_W-1:0] Imem2proc_tag;
   logic [IDX_W-1:0]  rd_idx;
   logic [TAG_W-1:0]  rd_tag;
   logic              wr_en;
   logic [IDX_W-1:0]  wr_idx;
   logic [TAG_W-1:0]  wr_tag;
   logic [63:0]       wr_data;
   logic [1:0]        proc2Imem_command;
   logic [63:0]       proc2Imem_addr;
   logic [63:0]       Icache_data_out;
   logic              Icache_valid_out;
   fill_state_e       dbg_state;

   int n_checks = 0;
   int n_fail   = 0;
   logic [IDX_W+TAG_W-1:0] exp_q[$];

   icache_fill_ctrl dut (
      .clock              (clock),
      .reset              (reset),
      .proc2Icache_addr   (proc2Icache_addr),
      .cachemem_data      (cachemem_data),
      .cachemem_valid     (cachemem_valid),
      .Imem2proc_response (Imem2proc_response),
      .Imem2proc_data     (Imem2proc_data),
      .Imem2proc_tag      (Imem2proc_tag),
      .rd_idx             (rd_idx),
      .rd_tag             (rd_tag),
      .wr_en              (wr_en),
      .wr_idx             (wr_idx),
      .wr_tag             (wr_tag),
      .wr_data            (wr_data),
      .proc2Imem_command  (proc2Imem_command),
      .proc2Imem_addr     (proc2Imem_addr),
      .Icache_data_out    (Icache_data_out),
      .Icache_valid_out   (Icache_valid_out),
      .dbg_state          (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached (got hang, expected finish)");
      $fatal(1, "watchdog");
   end

   // ---------------- driver tasks ----------------
   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic drive(input logic [63:0] addr, input logic cvalid,
                        input logic [MTAG_W-1:0] resp, input logic [MTAG_W-1:0] mtag,
                        input logic [63:0] mdata);
      proc2Icache_addr   = addr;
      cachemem_valid     = cvalid;
      Imem2proc_response = resp;
      Imem2proc_tag      = mtag;
      Imem2proc_data     = mdata;
   endtask

   // ---------------- checker ----------------
   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Fill check: write port against the oldest accepted miss.
   task automatic check_fill(input string tag, input logic [63:0] exp_data);
      logic [IDX_W+TAG_W-1:0] exp_line;
      check_eq({tag, "_wr_en"}, 64'(wr_en), 64'd1);
      if (exp_q.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s_sb: got fill, expected no pending miss", tag);
      end else begin
         exp_line = exp_q.pop_front();
         check_eq({tag, "_wr_line"}, 64'({wr_tag, wr_idx}), 64'(exp_line));
      end
      check_eq({tag, "_wr_data"}, wr_data, exp_data);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset = 1'b1;
      cachemem_data = 64'h0;
      drive(64'h1238, 1'b1, 4'd0, 4'd0, 64'h0);
      settle();
      check_eq("rst_state",   64'(dbg_state), 64'(IDLE));
      check_eq("rst_wr_en",   64'(wr_en), 64'd0);
      check_eq("rst_cmd",     64'(proc2Imem_command), 64'(BUS_NONE));
      check_eq("rst_valid",   64'(Icache_valid_out), 64'd0);
      check_eq("rst_rd_idx",  64'(rd_idx), 64'h47);
      check_eq("rst_rd_tag",  64'(rd_tag), 64'h4);
      next_cycle();
      next_cycle();
      reset = 1'b0;
      settle();
      check_eq("hit_valid",   64'(Icache_valid_out), 64'd1);
      check_eq("hit_cmd",     64'(proc2Imem_command), 64'(BUS_NONE));

      // ---- miss at 0x1238, accepted with tag 3 ----
      next_cycle();
      drive(64'h1238, 1'b0, 4'd3, 4'd0, 64'h0);
      settle();
      check_eq("miss_cmd",    64'(proc2Imem_command), 64'(BUS_LOAD));
      check_eq("miss_addr",   proc2Imem_addr, 64'h1238);
      exp_q.push_back({22'h4, 7'h47});
      next_cycle();
      drive(64'h1238, 1'b0, 4'd0, 4'd0, 64'h0);
      settle();
      check_eq("wait_state",  64'(dbg_state), 64'(WAIT));
      check_eq("wait_cmd",    64'(proc2Imem_command), 64'(BUS_NONE));
      for (int i = 0; i < 2; i++) begin
         next_cycle();
         settle();
         check_eq("wait_wr_en", 64'(wr_en), 64'd0);
      end
      // foreign tag 7 is someone else's data
      next_cycle();
      drive(64'h1238, 1'b0, 4'd0, 4'd7, 64'h5555);
      settle();
      check_eq("foreign_wr_en", 64'(wr_en), 64'd0);
      next_cycle();
      drive(64'h1238, 1'b0, 4'd0, 4'd3, 64'hDEAD_BEEF);
      settle();
      check_eq("foreign_state", 64'(dbg_state), 64'(WAIT));
      check_fill("fill1", 64'hDEAD_BEEF);
      check_eq("fill1_cmd",   64'(proc2Imem_command), 64'(BUS_NONE));
`ifdef ICACHE_FILL_BYPASS_EN
      check_eq("bypass_valid", 64'(Icache_valid_out), 64'd1);
      check_eq("bypass_data",  Icache_data_out, 64'hDEAD_BEEF);
`else
      check_eq("nobypass_valid", 64'(Icache_valid_out), 64'd0);
`endif
      next_cycle();
      cachemem_data = 64'hDEAD_BEEF;
      drive(64'h1238, 1'b1, 4'd0, 4'd0, 64'h0);
      settle();
      check_eq("after_fill_state", 64'(dbg_state), 64'(IDLE));
      check_eq("after_fill_wr_en", 64'(wr_en), 64'd0);
      check_eq("after_fill_valid", 64'(Icache_valid_out), 64'd1);
      check_eq("after_fill_data",  Icache_data_out, 64'hDEAD_BEEF);

      // ---- refused request: response 0 for 3 cycles ----
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         drive(64'h5678, 1'b0, 4'd0, 4'd0, 64'h0);
         settle();
         check_eq("refuse_cmd",   64'(proc2Imem_command), 64'(BUS_LOAD));
         check_eq("refuse_state", 64'(dbg_state), 64'(IDLE));
      end
      next_cycle();
      drive(64'h5678, 1'b0, 4'd2, 4'd0, 64'h0);
      settle();
      check_eq("accept_addr", proc2Imem_addr, 64'h5678);
      exp_q.push_back({22'h15, 7'h4F});

      // ---- redirect to 0x2000 while waiting ----
      next_cycle();
      drive(64'h2000, 1'b0, 4'd0, 4'd0, 64'h0);
      settle();
      check_eq("redir_state", 64'(dbg_state), 64'(WAIT));
      check_eq("redir_cmd",   64'(proc2Imem_command), 64'(BUS_NONE));
      next_cycle();
      drive(64'h2000, 1'b0, 4'd0, 4'd2, 64'h1234_5678_9ABC_DEF0);
      settle();
      check_fill("fill2", 64'h1234_5678_9ABC_DEF0);
      check_eq("fill2_cmd",   64'(proc2Imem_command), 64'(BUS_NONE));
      check_eq("fill2_valid", 64'(Icache_valid_out), 64'd0);
      next_cycle();
      drive(64'h2000, 1'b0, 4'd0, 4'd0, 64'h0);
      settle();
      check_eq("redir_new_cmd",  64'(proc2Imem_command), 64'(BUS_LOAD));
      check_eq("redir_new_addr", proc2Imem_addr, 64'h2000);

      // ---- reset in the middle of WAIT ----
      next_cycle();
      drive(64'h1238, 1'b0, 4'd5, 4'd0, 64'h0);
      next_cycle();
      drive(64'h1238, 1'b0, 4'd0, 4'd0, 64'h0);
      settle();
      check_eq("pre_rst_state", 64'(dbg_state), 64'(WAIT));
      reset = 1'b1;
      settle();
      check_eq("midrst_state", 64'(dbg_state), 64'(IDLE));
      check_eq("midrst_cmd",   64'(proc2Imem_command), 64'(BUS_NONE));
      check_eq("midrst_wr_en", 64'(wr_en), 64'd0);
      next_cycle();
      next_cycle();
      reset = 1'b0;
      drive(64'h1238, 1'b1, 4'd0, 4'd5, 64'hBAD0_BAD0);
      settle();
      check_eq("late_wr_en",  64'(wr_en), 64'd0);
      next_cycle();
      settle();
      check_eq("late_state",  64'(dbg_state), 64'(IDLE));
      check_eq("sb_empty",    64'(exp_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
